// File: rtl/uart_tx_fifo_reader.sv
// Drains the UART TX async FIFO read port and serializes each byte as 8N1/8N2, LSB first.
// Optional even-parity bit between data and stop when UART_PARITY_EN is defined.
module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_ren,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // FIFO read handshake: fifo_ren is a single-cycle pulse issued only after
    // fifo_empty was sampled low in IDLE; fifo_data is taken the following cycle.

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_fifo_reader: CLKS_PER_BIT must be 2 or more");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_fifo_reader: STOP_BITS must be 1 or 2");
    end

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd6
    } state_t;
`endif

    state_t          state;
    state_t          state_n;
    logic [BW-1:0]   baud_cnt;
    logic [BW-1:0]   baud_cnt_n;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_n;
    logic [7:0]      data_reg;
    logic            baud_done;
    logic            timed_state;
    logic            tx_n;
    logic            fifo_ren_n;
    logic            busy_n;
    logic            tx_done_n;

    assign baud_done   = (baud_cnt == BAUD_MAX);
    assign timed_state = (state != IDLE) && (state != FETCH) && (state != LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data_reg <= '0;
            tx       <= 1'b1;
            fifo_ren <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            if (state == LOAD) begin
                data_reg <= fifo_data;
            end
            tx       <= tx_n;
            fifo_ren <= fifo_ren_n;
            busy     <= busy_n;
            tx_done  <= tx_done_n;
        end
    end

    // Next state; fifo_empty only matters in IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = FETCH;
                end
            end
            FETCH: state_n = LOAD;
            LOAD:  state_n = START;
            START: begin
                if (baud_done) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_done && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done && bit_cnt == STOP_LAST) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Counters reload on every state change; bit_cnt also indexes stop bits.
    always_comb begin
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        if (state_n == state && timed_state) begin
            if (baud_done) begin
                baud_cnt_n = '0;
                bit_cnt_n  = bit_cnt + 3'd1;
            end else begin
                baud_cnt_n = baud_cnt + 1'b1;
                bit_cnt_n  = bit_cnt;
            end
        end
    end

    // Outputs are computed from the next state so the registers line up with it.
    always_comb begin
        tx_n       = 1'b1;
        fifo_ren_n = (state_n == FETCH);
        busy_n     = (state_n != IDLE);
        tx_done_n  = (state == STOP) && (state_n == IDLE);
        case (state_n)
            START:  tx_n = 1'b0;
            DATA:   tx_n = data_reg[bit_cnt_n];
`ifdef UART_PARITY_EN
            PARITY: tx_n = ^data_reg;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: FIFO models, directed waveform checks and a frame-decoding scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_fifo_reader;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LEN1 = (9 + 1 + PAR) * CPB;
  localparam int LEN2 = (9 + 2 + PAR) * CPB;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 1 (one stop bit)
  logic       fifo_empty, fifo_ren, tx, busy, tx_done;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] mem [0:63];
  int         push_cnt = 0;
  int         pop_cnt = 0;
  assign fifo_empty = (push_cnt == pop_cnt);
  always @(posedge clk) begin
    if (fifo_ren && push_cnt != pop_cnt) begin
      fifo_data <= mem[pop_cnt % 64];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // DUT 2 (two stop bits)
  logic       fifo_empty2, fifo_ren2, tx2, busy2, tx_done2;
  logic [7:0] fifo_data2 = 8'h00;
  logic [7:0] mem2 [0:63];
  int         push_cnt2 = 0;
  int         pop_cnt2 = 0;
  assign fifo_empty2 = (push_cnt2 == pop_cnt2);
  always @(posedge clk) begin
    if (fifo_ren2 && push_cnt2 != pop_cnt2) begin
      fifo_data2 <= mem2[pop_cnt2 % 64];
      pop_cnt2   <= pop_cnt2 + 1;
    end
  end

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_ren(fifo_ren), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
    .fifo_ren(fifo_ren2), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected tx level per cycle; cycle 0 is the cycle fifo_empty first drops.
  function automatic logic [63:0] exp_tx_wave(input logic [7:0] b);
    logic [63:0] w;
    int seg;
    w = '1;
    for (int n = 3; n < 64; n++) begin
      seg = (n - 3) / CPB;
      if (seg == 0) w[n] = 1'b0;
      else if (seg <= 8) w[n] = b[seg-1];
      else if (PAR == 1 && seg == 9) w[n] = ^b;
    end
    return w;
  endfunction

  function automatic logic [63:0] one_hot(input int n);
    logic [63:0] w;
    w = '0;
    w[n] = 1'b1;
    return w;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] w;
    w = '0;
    for (int n = lo; n <= hi; n++) w[n] = 1'b1;
    return w;
  endfunction

  // driver tasks
  task automatic capture1(input logic [7:0] b, output logic [63:0] w_tx, output logic [63:0] w_ren,
                          output logic [63:0] w_busy, output logic [63:0] w_done);
    @(negedge clk);
    mem[push_cnt % 64] = b;
    push_cnt = push_cnt + 1;
    exp_q.push_back(b);
    for (int n = 0; n < 64; n++) begin
      if (n > 0) @(negedge clk);
      w_tx[n] = tx; w_ren[n] = fifo_ren; w_busy[n] = busy; w_done[n] = tx_done;
    end
  endtask

  task automatic capture2(input logic [7:0] b, output logic [63:0] w_tx, output logic [63:0] w_ren,
                          output logic [63:0] w_busy, output logic [63:0] w_done);
    @(negedge clk);
    mem2[push_cnt2 % 64] = b;
    push_cnt2 = push_cnt2 + 1;
    for (int n = 0; n < 64; n++) begin
      if (n > 0) @(negedge clk);
      w_tx[n] = tx2; w_ren[n] = fifo_ren2; w_busy[n] = busy2; w_done[n] = tx_done2;
    end
  endtask

  // monitor: decodes each frame on tx by mid-bit sampling and pops the scoreboard
  initial begin
    logic [11:0] seg_v;
    logic [7:0]  eb;
    int          k;
    bit          on;
    on = 1'b0;
    k = 0;
    seg_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        on = 1'b0;
      end else begin
        if (fifo_ren) check("ren_nonempty", (push_cnt != pop_cnt), 1);
        if (!on && tx == 1'b0) begin
          on = 1'b1; k = 0; seg_v = '0;
        end
        if (on) begin
          if (k < LEN1) begin
            if (k % CPB == CPB / 2) seg_v[k / CPB] = tx;
            k++;
          end else begin
            check("frame_tx_done", tx_done, 1);
            check("frame_start_bit", seg_v[0], 0);
            check("frame_stop_bit", seg_v[9+PAR], 1);
            check("frame_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              eb = exp_q.pop_front();
              check("frame_data", seg_v[8:1], eb);
`ifdef UART_PARITY_EN
              check("frame_parity", seg_v[9], ^eb);
`endif
            end
            on = 1'b0;
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [63:0] wt, wr, wb, wd;
    int bad, ren_cnt, f1, f2;
    logic prev;

    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_ren", fifo_ren, 0);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_tx2", tx2, 1);
    rst = 1'b0;

    // idle with empty FIFO
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_ren !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("idle_100_cycles", bad, 0);

    // single byte 0xA5
    capture1(8'hA5, wt, wr, wb, wd);
    check("a5_tx_wave", wt, exp_tx_wave(8'hA5));
    check("a5_ren_wave", wr, one_hot(1));
    check("a5_busy_wave", wb, span(1, 2 + LEN1));
    check("a5_done_wave", wd, one_hot(3 + LEN1));

    // back-to-back 0x00, 0xFF
    @(negedge clk);
    mem[push_cnt % 64] = 8'h00; push_cnt = push_cnt + 1; exp_q.push_back(8'h00);
    mem[push_cnt % 64] = 8'hFF; push_cnt = push_cnt + 1; exp_q.push_back(8'hFF);
    ren_cnt = 0; f1 = -1; f2 = -1; prev = tx;
    for (int n = 0; n < 120; n++) begin
      if (n > 0) @(negedge clk);
      if (fifo_ren) ren_cnt++;
      if (prev && !tx) begin
        if (f1 < 0) f1 = n;
        else if (f2 < 0) f2 = n;
      end
      prev = tx;
    end
    check("b2b_ren_pulses", ren_cnt, 2);
    check("b2b_first_start", f1, 3);
    check("b2b_gap", f2 - (f1 + LEN1), 3);

    // two stop bits, 0x3C
    capture2(8'h3C, wt, wr, wb, wd);
    check("stop2_tx_wave", wt, exp_tx_wave(8'h3C));
    check("stop2_ren_wave", wr, one_hot(1));
    check("stop2_busy_wave", wb, span(1, 2 + LEN2));
    check("stop2_done_wave", wd, one_hot(3 + LEN2));

    // parity-sensitive bytes
    capture1(8'h07, wt, wr, wb, wd);
    check("b07_tx_wave", wt, exp_tx_wave(8'h07));
    check("b07_done_wave", wd, one_hot(3 + LEN1));
    capture1(8'h03, wt, wr, wb, wd);
    check("b03_tx_wave", wt, exp_tx_wave(8'h03));
    check("b03_done_wave", wd, one_hot(3 + LEN1));

    // reset during DATA bit 3 of 0x5A; the byte is dropped, so nothing is queued
    @(negedge clk);
    mem[push_cnt % 64] = 8'h5A; push_cnt = push_cnt + 1;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_tx_bit3", tx, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_tx", tx, 1);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", tx_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_ren !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("post_reset_idle", bad, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
Transmit-side consumer of the UART controller's TX async FIFO. It sits on the FIFO read port in the UART clock domain. While the FIFO is non-empty it pops one byte at a time and serializes each byte onto the UART TX line as 8N1 or 8N2, LSB first. This is the reader that drains what the host side writes into the FIFO.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit; legal range is 2 or more (434 gives 115200 baud at 50 MHz).
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  single clock for the block, which is the FIFO read clock (rclk domain).
rst  input  1  asynchronous, active-high reset.
fifo_empty  input  1  FIFO empty flag, synchronous to clk.
fifo_data  input  8  FIFO read data; valid in the cycle after fifo_ren is high.
fifo_ren  output  1  FIFO read enable; one-cycle pulse per byte.
tx  output  1  UART serial output; idle level is high.
busy  output  1  high from FETCH through the end of STOP.
tx_done  output  1  one-cycle pulse after each frame's stop bit(s) complete.

Behaviour:
- All outputs are registered. While rst is high: tx=1, fifo_ren=0, busy=0, tx_done=0, FSM=IDLE, and the bit counter and baud counter are 0.
- Reset asserted mid-frame: tx returns high immediately (asynchronously). The byte in flight is dropped and is not re-read.
- FSM states: IDLE, FETCH, LOAD, START, DATA, [PARITY], STOP.
- IDLE: if fifo_empty=0 at the clock edge, go to FETCH; otherwise stay in IDLE.
- FETCH: fifo_ren=1 for exactly this one cycle. Unconditionally go to LOAD.
- LOAD: capture fifo_data into the shift register at the end of this cycle, then go to START. fifo_empty is not re-checked here, because FETCH was entered only when the FIFO was non-empty.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first. Each bit is held for CLKS_PER_BIT cycles. A 3-bit counter runs 0 to 7 and the state exits when the counter reaches 7 and the baud counter expires.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with tx_done=1 for the first IDLE cycle.
- Latency: if fifo_empty is seen low in IDLE at cycle 0, fifo_ren=1 in cycle 1 and tx falls at cycle 3.
- Frame length, from first START cycle to last STOP cycle: (1+8+STOP_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
- Back-to-back frames: the inter-frame gap is exactly 3 cycles of tx=1 (IDLE, FETCH, LOAD) beyond the stop bit(s).
- Baud counter: width is $clog2(CLKS_PER_BIT). It counts 0 to CLKS_PER_BIT-1, wraps to 0, and reloads on every state change.
- fifo_empty is ignored in every state except IDLE.
- fifo_ren is never asserted while fifo_empty=1 is sampled in IDLE. This prevents reading an empty FIFO.
- busy=1 in FETCH, LOAD, START, DATA, PARITY and STOP; busy=0 in IDLE.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
- Undefined: DATA goes directly to STOP, and no parity logic or state encoding is present.

Test Plan:
1. Reset with CLKS_PER_BIT=4 and fifo_empty=1 held -> tx=1, fifo_ren=0, busy=0 for 100 cycles with no read pulse.
2. FIFO with a single byte 0xA5; fifo_empty drops at cycle 0 -> fifo_ren high only in cycle 1. tx=0 during cycles 3-6. Data bits 1,0,1,0,0,1,0,1 follow at 4 cycles each. Stop is high for 4 cycles. tx_done pulses at cycle 43. The bench decodes 0xA5.
3. Back-to-back bytes 0x00 then 0xFF with fifo_empty low throughout -> exactly 2 fifo_ren pulses. The gap between the end of the first stop bit and the second start bit is 3 cycles. The bench decodes 0x00 then 0xFF in order.
4. STOP_BITS=2 with byte 0x3C -> stop high for 8 cycles. The frame is 44 cycles from start to end of stop.
5. rst asserted during DATA bit 3 of byte 0x5A -> tx=1 in the same cycle, busy=0, no tx_done. After release with fifo_empty=1, the block stays idle.
6. With UART_PARITY_EN defined, bytes 0x07 and 0x03 -> parity bits 1 and 0 respectively. The frame is 44 cycles at CLKS_PER_BIT=4 with STOP_BITS=1.
